// File: rtl/rr_mux_nch_if.sv
// Handshake bundle for rr_mux_nch: N source channels in, one registered channel out.
// master drives the sources and the consumer's ready; slave is the mux itself.
interface rr_mux_nch_if #(
    parameter int W = 4,
    parameter int N = 4
);
    localparam int SELW = $clog2(N);

    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SELW-1:0] s;
    logic [W-1:0]    out_data;
    logic [SELW-1:0] out_src;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output in_data,
        output in_valid,
        output mode,
        output s,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_src,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  mode,
        input  s,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_src,
        output out_valid
    );
endinterface

// File: rtl/rr_mux_nch.sv
// N-channel W-bit registered mux: round-robin arbitration (mode 0) or fixed select (mode 1).
// Latency: one cycle from input accept to out_valid; full throughput.
// Backpressure: while out_valid & ~out_ready the register holds and every in_ready is low.
module rr_mux_nch #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_mux_nch_if.slave  bus
);
    localparam int SELW = $clog2(N);
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    logic [SELW-1:0] ptr;
    logic [W-1:0]    data_q;
    logic [SELW-1:0] src_q;
    logic            valid_q;

    logic            load;
    logic [N-1:0]    rr_hi;
    logic [N-1:0]    rr_pool;
    logic [N-1:0]    rr_grant;
    logic [N-1:0]    fix_grant;
    logic [N-1:0]    grant;
    logic [SELW-1:0] gidx;
    logic [W-1:0]    gdata;
    logic [SELW-1:0] ptr_nxt;

    assign load = ~valid_q | bus.out_ready;

    // Round-robin: lowest valid index at or above ptr, otherwise wrap to the lowest valid overall.
    assign rr_hi    = bus.in_valid & ({N{1'b1}} << ptr);
    assign rr_pool  = (|rr_hi) ? rr_hi : bus.in_valid;
    assign rr_grant = rr_pool & (~rr_pool + ONE_N);

    // An out-of-range select shifts the single bit off the top, giving no grant.
    assign fix_grant = (ONE_N << bus.s) & bus.in_valid;

    assign grant = bus.mode ? fix_grant : rr_grant;

    // rst_n gating keeps every in_ready low while reset is held.
    assign bus.in_ready = grant & {N{load & rst_n}};

    always_comb begin
        gidx  = '0;
        gdata = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                gidx  = SELW'(i);
                gdata = bus.in_data[i*W +: W];
            end
        end
    end

    assign ptr_nxt = (gidx == SELW'(N - 1)) ? '0 : gidx + SELW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            if (|grant) begin
                data_q  <= gdata;
                src_q   <= gidx;
                valid_q <= 1'b1;
                if (!bus.mode) begin
                    ptr <= ptr_nxt;
                end
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.out_valid = valid_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.in_ready));

    a_stall_holds: assert property (@(posedge clk) disable iff (!rst_n)
        (valid_q && !bus.out_ready) |=> (valid_q && $stable(data_q) && $stable(src_q)));

    a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
        ((bus.in_ready & ~bus.in_valid) == '0));
endmodule

// File: tb/tb_rr_mux_nch.sv
// Directed bench for rr_mux_nch (W=4, N=4): stimulus pushes hand-computed words into a
// scoreboard queue, a negedge monitor pops and compares every transfer the DUT presents.
module tb_rr_mux_nch;
    localparam int W = 4;
    localparam int N = 4;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] src;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;
    exp_t sb[$];

    rr_mux_nch_if #(.W(W), .N(N)) bus ();

    rr_mux_nch #(.W(W), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic [1:0] src);
        exp_t e;
        e.data = d;
        e.src  = src;
        sb.push_back(e);
    endtask

    // Monitor: a transfer seen mid-cycle completes on the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", {26'd0, bus.out_src, bus.out_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(e.data));
                chk("out_src", 32'(bus.out_src), 32'(e.src));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rr_seq [5];
        checks = 0;
        fails  = 0;
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset with every channel valid.
        rst_n         = 1'b0;
        bus.in_data   = {4'h8, 4'h4, 4'h2, 4'h1};
        bus.in_valid  = 4'b1111;
        bus.mode      = 1'b0;
        bus.s         = 2'd0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_src", 32'(bus.out_src), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        rst_n = 1'b1;

        // Round-robin, all valid: ch0..ch3 then ch0 again, back-to-back.
        push(4'h1, 2'd0);
        push(4'h2, 2'd1);
        push(4'h4, 2'd2);
        push(4'h8, 2'd3);
        push(4'h1, 2'd0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr_all_ready_%0d", k), 32'(bus.in_ready), 32'(rr_seq[k]));
            step();
        end

        // Only ch2 and ch0 valid with ptr = 1: ch2 first, then ch0, ptr lands on 1.
        bus.in_valid = 4'b0101;
        push(4'h4, 2'd2);
        push(4'h1, 2'd0);
        #1;
        chk("rr_sparse_ready_0", 32'(bus.in_ready), 32'b0100);
        step();
        #1;
        chk("rr_sparse_ready_1", 32'(bus.in_ready), 32'b0001);
        step();
        bus.in_valid = 4'b1111;
        push(4'h2, 2'd1);
        #1;
        chk("rr_ptr_wrapped_to_1", 32'(bus.in_ready), 32'b0010);
        step();
        bus.in_valid = 4'b0000;
        #1;
        chk("idle_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

        // Fixed select s = 2: only ch2 is ever taken.
        bus.mode     = 1'b1;
        bus.s        = 2'd2;
        bus.in_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            push(4'h4, 2'd2);
            #1;
            chk($sformatf("fix_ready_%0d", k), 32'(bus.in_ready), 32'b0100);
            step();
        end
        bus.in_valid = 4'b1011;
        #1;
        chk("fix_sel_invalid_ready", 32'(bus.in_ready), 32'd0);
        step();
        chk("fix_sel_invalid_out_valid", 32'(bus.out_valid), 32'd0);

        // Back to round-robin: ptr held at 2 through fixed mode.
        bus.mode     = 1'b0;
        bus.in_valid = 4'b1111;
        push(4'h4, 2'd2);
        #1;
        chk("rr_ptr_held_ready", 32'(bus.in_ready), 32'b0100);
        step();

        // Stall three cycles: register holds, no input accepted.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall_ready_%0d", k), 32'(bus.in_ready), 32'd0);
            chk($sformatf("stall_valid_%0d", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stall_data_%0d", k), 32'(bus.out_data), 32'h4);
            chk($sformatf("stall_src_%0d", k), 32'(bus.out_src), 32'd2);
            step();
        end
        bus.out_ready = 1'b1;
        push(4'h8, 2'd3);
        push(4'h1, 2'd0);
        #1;
        chk("resume_ready_0", 32'(bus.in_ready), 32'b1000);
        step();
        #1;
        chk("resume_ready_1", 32'(bus.in_ready), 32'b0001);
        step();
        bus.in_valid = 4'b0000;
        step();

        // Load ch2, stall, then pulse reset: the word is dropped and ptr returns to 0.
        bus.in_valid = 4'b0100;
        step();
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b0;
        #1;
        chk("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_reset_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b1111;
        push(4'h1, 2'd0);
        #1;
        chk("post_reset_ptr0_ready", 32'(bus.in_ready), 32'b0001);
        step();
        bus.in_valid = 4'b0000;

        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            step();
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
